// File: rtl/pc_bus_pkg.sv
// Shared types and constants for the PC system-board interrupt path:
// INTA state encoding, register selects and the fixed-priority encoder.
package pc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK1  = 2'd1,
        WAIT2 = 2'd2,
        ACK2  = 2'd3
    } inta_state_t;

    localparam logic       A0_CMD    = 1'b0;
    localparam logic       A0_MASK   = 1'b1;
    localparam int         EOI_BIT   = 5;
    localparam logic [7:0] IMR_RESET = 8'hFF;

    // Lowest set index wins (IRQ0 highest); an empty vector yields 7, which is
    // also the level reported for a spurious acknowledge.
    function automatic logic [2:0] prio_enc(input logic [7:0] v);
        prio_enc = 3'd7;
        for (int i = 7; i >= 0; i--)
            if (v[i]) prio_enc = 3'(i);
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Per-bit two-flop synchronizer with a rising-edge pulse; EDGE selects whether
// q carries the edge pulse or the synchronized level.
module irq_sync #(
    parameter int W    = 8,
    parameter bit EDGE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        logic s0, s1, prev;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s0   <= 1'b0;
                s1   <= 1'b0;
                prev <= 1'b0;
            end else begin
                s0   <= d[i];
                s1   <= s0;
                prev <= s1;
            end
        end

        assign q[i] = EDGE ? (s1 & ~prev) : s1;
    end

endmodule

// File: rtl/intr_ctrl.sv
// 8-input fixed-priority interrupt controller driven by 8288 command strobes.
// Define INTR_CTRL_LEVEL_EN for level-triggered requests (IRR follows irq).
module intr_ctrl
    import pc_bus_pkg::*;
#(
    parameter logic [7:0] VEC_BASE = 8'h08
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irq,
    input  logic       cs_n,
    input  logic       a0,
    input  logic       iorc_n,
    input  logic       aiowc_n,
    input  logic       inta_n,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       dout_en,
    output logic       intr
);

`ifdef INTR_CTRL_LEVEL_EN
    localparam bit SYNC_EDGE = 1'b0;
`else
    localparam bit SYNC_EDGE = 1'b1;
`endif

    logic [7:0]  irq_s;
    logic [7:0]  irr, isr, imr;
    logic [7:0]  irr_nxt, isr_nxt, pending;
    logic [2:0]  pend_lvl, isr_lvl, level;
    logic        aw_prev, ia_prev;
    logic        wr_stb, ia_fall, eoi, ack_hit, intr_nxt, rd_en;
    inta_state_t state;

    irq_sync #(.W(8), .EDGE(SYNC_EDGE)) u_irq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (irq),
        .q     (irq_s)
    );

    assign wr_stb   = !aiowc_n && aw_prev && !cs_n;
    assign ia_fall  = !inta_n && ia_prev;
    assign eoi      = wr_stb && (a0 == A0_CMD) && din[EOI_BIT];
    assign pending  = irr & ~imr;
    assign pend_lvl = prio_enc(pending);
    assign isr_lvl  = prio_enc(isr);
    assign ack_hit  = ia_fall && (state == IDLE) && (|pending);
    assign intr_nxt = (|pending) && (!(|isr) || (pend_lvl < isr_lvl));

    // The acknowledge clear is applied last so it beats a same-cycle new edge.
    always_comb begin
        isr_nxt = isr;
        if (eoi && (|isr)) isr_nxt[isr_lvl] = 1'b0;
        if (ack_hit)       isr_nxt[pend_lvl] = 1'b1;
`ifdef INTR_CTRL_LEVEL_EN
        irr_nxt = irq_s;
`else
        irr_nxt = irr | irq_s;
        if (ack_hit) irr_nxt[pend_lvl] = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irr     <= 8'h00;
            isr     <= 8'h00;
            imr     <= IMR_RESET;
            intr    <= 1'b0;
            aw_prev <= 1'b1;
            ia_prev <= 1'b1;
        end else begin
            irr     <= irr_nxt;
            isr     <= isr_nxt;
            intr    <= intr_nxt;
            aw_prev <= aiowc_n;
            ia_prev <= inta_n;
            if (wr_stb && (a0 == A0_MASK)) imr <= din;
        end
    end

    // Level is latched once on the first pulse; later IMR writes cannot move it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            level <= 3'd0;
        end else begin
            case (state)
                IDLE:    if (ia_fall) begin
                             state <= ACK1;
                             level <= pend_lvl;
                         end
                ACK1:    if (inta_n)  state <= WAIT2;
                WAIT2:   if (ia_fall) state <= ACK2;
                ACK2:    if (inta_n)  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_en = !iorc_n && !cs_n && inta_n && (state == IDLE);

    always_comb begin
        dout_en = 1'b0;
        dout    = 8'h00;
        if ((state == ACK2) && !inta_n) begin
            dout_en = 1'b1;
            dout    = {VEC_BASE[7:3], level};
        end else if (rd_en) begin
            dout_en = 1'b1;
            dout    = (a0 == A0_MASK) ? imr : isr;
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed and randomized bench for intr_ctrl against a transaction-level
// model of the request/in-service/mask registers and the two-pulse acknowledge.
module tb_intr_ctrl;

    localparam logic [7:0] VB = 8'h08;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq;
    logic       cs_n, a0, iorc_n, aiowc_n, inta_n;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_en;
    logic       intr;

    int n_chk  = 0;
    int n_fail = 0;

    intr_ctrl #(.VEC_BASE(VB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq     (irq),
        .cs_n    (cs_n),
        .a0      (a0),
        .iorc_n  (iorc_n),
        .aiowc_n (aiowc_n),
        .inta_n  (inta_n),
        .din     (din),
        .dout    (dout),
        .dout_en (dout_en),
        .intr    (intr)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [7:0] m_irr, m_isr, m_imr;
    logic       m_intr;
    logic [2:0] m_level;
    logic [7:0] h1, h2, h3;     // irq as sampled 1, 2 and 3 edges ago
    logic       m_aw, m_ia;
    int         ack_n;          // acknowledge pulses seen in the current sequence

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++)
            if (v[i]) return i;
        return 8;
    endfunction

    task automatic model_reset();
        m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'hFF; m_intr = 1'b0; m_level = 3'd0;
        h1 = 8'h00; h2 = 8'h00; h3 = 8'h00; m_aw = 1'b1; m_ia = 1'b1; ack_n = 0;
    endtask

    task automatic model_step();
        logic [7:0] pend, new_irr;
        int p, s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pend   = m_irr & ~m_imr;
        p      = lowest(pend);
        s      = lowest(m_isr);
        m_intr = (pend != 0) && (m_isr == 0 || p < s);
`ifdef INTR_CTRL_LEVEL_EN
        new_irr = h2;
`else
        new_irr = m_irr | (h2 & ~h3);
`endif
        if (!aiowc_n && m_aw && !cs_n) begin
            if (a0) m_imr = din;
            else if (din[5] && s < 8) m_isr[s] = 1'b0;
        end
        if (!inta_n && m_ia) begin
            if (ack_n == 0) begin
                if (p < 8) begin
                    m_level  = 3'(p);
                    m_isr[p] = 1'b1;
`ifndef INTR_CTRL_LEVEL_EN
                    new_irr[p] = 1'b0;
`endif
                end else begin
                    m_level = 3'd7;
                end
                ack_n = 1;
            end else begin
                ack_n = 2;
            end
        end else if (ack_n == 2 && inta_n) begin
            ack_n = 0;
        end
        m_irr = new_irr;
        h3 = h2; h2 = h1; h1 = irq;
        m_aw = aiowc_n; m_ia = inta_n;
    endtask

    task automatic check_outputs();
        logic       e_en;
        logic [7:0] e_dout;
        e_en   = 1'b0;
        e_dout = 8'h00;
        if (ack_n == 2 && !inta_n) begin
            e_en   = 1'b1;
            e_dout = {VB[7:3], m_level};
        end else if (ack_n == 0 && inta_n && !iorc_n && !cs_n) begin
            e_en   = 1'b1;
            e_dout = a0 ? m_imr : m_isr;
        end
        chk("intr", {7'd0, intr}, {7'd0, m_intr});
        chk("dout_en", {7'd0, dout_en}, {7'd0, e_en});
        chk("dout", dout, e_dout);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic bus_wr(input logic a, input logic [7:0] d, input logic sel);
        cs_n = !sel; a0 = a; din = d; aiowc_n = 1'b0;
        tick();
        aiowc_n = 1'b1; cs_n = 1'b1;
        tick();
    endtask

    task automatic bus_rd(input logic a, output logic [7:0] d);
        cs_n = 1'b0; a0 = a; iorc_n = 1'b0;
        tick();
        d = dout;
        iorc_n = 1'b1; cs_n = 1'b1;
        tick();
    endtask

    task automatic inta_seq(output logic [7:0] vec, output logic en);
        inta_n = 1'b0; ticks(2);
        inta_n = 1'b1; ticks(2);
        inta_n = 1'b0; tick();
        vec = dout; en = dout_en;
        tick();
        inta_n = 1'b1; tick();
    endtask

    logic [7:0] v, r;
    logic       e;

    initial begin
        rst_n = 1'b0; irq = 8'h00; cs_n = 1'b1; a0 = 1'b0;
        iorc_n = 1'b1; aiowc_n = 1'b1; inta_n = 1'b1; din = 8'h00;
        model_reset();
        ticks(2);
        chk("rst_intr", {7'd0, intr}, 8'h00);
        chk("rst_dout_en", {7'd0, dout_en}, 8'h00);
        chk("rst_dout", dout, 8'h00);
        rst_n = 1'b1;
        tick();
        bus_rd(1'b1, r);
        chk("rst_imr", r, 8'hFF);

`ifndef INTR_CTRL_LEVEL_EN
        // single request, latency and vector
        bus_wr(1'b1, 8'h00, 1'b1);
        irq = 8'h08;
        ticks(3);
        chk("irq3_lat3", {7'd0, intr}, 8'h00);
        tick();
        chk("irq3_lat4", {7'd0, intr}, 8'h01);
        inta_seq(v, e);
        chk("irq3_vec", v, 8'h0B);
        chk("irq3_en", {7'd0, e}, 8'h01);
        chk("irq3_intr_off", {7'd0, intr}, 8'h00);
        bus_rd(1'b0, r);
        chk("irq3_isr", r, 8'h08);

        // simultaneous requests, priority then EOI
        irq = 8'h00; do_reset();
        bus_wr(1'b1, 8'h00, 1'b1);
        irq = 8'h22;
        ticks(5);
        inta_seq(v, e);
        chk("pri_vec1", v, 8'h09);
        chk("pri_intr_blk", {7'd0, intr}, 8'h00);
        bus_wr(1'b0, 8'h20, 1'b1);
        chk("pri_eoi_intr", {7'd0, intr}, 8'h01);
        inta_seq(v, e);
        chk("pri_vec5", v, 8'h0D);
        bus_wr(1'b0, 8'h20, 1'b1);

        // nesting
        irq = 8'h00; do_reset();
        bus_wr(1'b1, 8'h00, 1'b1);
        irq = 8'h04;
        ticks(4);
        inta_seq(v, e);
        chk("nest_vec2", v, 8'h0A);
        irq = 8'h44;
        ticks(6);
        chk("nest_lo_blk", {7'd0, intr}, 8'h00);
        irq = 8'h45;
        ticks(4);
        chk("nest_hi_intr", {7'd0, intr}, 8'h01);
        inta_seq(v, e);
        chk("nest_vec0", v, 8'h08);
        bus_wr(1'b0, 8'h20, 1'b1);
        bus_wr(1'b0, 8'h20, 1'b1);
        chk("nest_irq6_intr", {7'd0, intr}, 8'h01);
        inta_seq(v, e);
        chk("nest_vec6", v, 8'h0E);
`endif

        // masked request, then unmask
        irq = 8'h00; do_reset();
        irq = 8'h01;
        ticks(6);
        chk("mask_intr0", {7'd0, intr}, 8'h00);
        bus_wr(1'b1, 8'hFE, 1'b1);
        chk("unmask_intr", {7'd0, intr}, 8'h01);

        // spurious acknowledge, reset between pulses
        irq = 8'h00; do_reset();
        bus_wr(1'b1, 8'h00, 1'b1);
        inta_seq(v, e);
        chk("spur_vec", v, 8'h0F);
        bus_rd(1'b0, r);
        chk("spur_isr", r, 8'h00);
        inta_n = 1'b0; ticks(2);
        inta_n = 1'b1; tick();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; tick();
        inta_n = 1'b0; ticks(2);
        chk("rst_mid_en", {7'd0, dout_en}, 8'h00);
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();

`ifdef INTR_CTRL_LEVEL_EN
        irq = 8'h00; do_reset();
        bus_wr(1'b1, 8'h00, 1'b1);
        irq = 8'h10;
        ticks(4);
        chk("lvl_intr", {7'd0, intr}, 8'h01);
        inta_seq(v, e);
        chk("lvl_vec", v, 8'h0C);
        chk("lvl_blk", {7'd0, intr}, 8'h00);
        bus_wr(1'b0, 8'h20, 1'b1);
        chk("lvl_reassert", {7'd0, intr}, 8'h01);
        irq = 8'h00;
        ticks(4);
        chk("lvl_drop", {7'd0, intr}, 8'h00);
`endif

        // randomized traffic, every cycle compared against the model
        irq = 8'h00; do_reset();
        for (int k = 0; k < 500; k++) begin
            case ($urandom_range(0, 7))
                0, 1: begin irq = 8'($urandom); tick(); end
                2:    bus_wr(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
                3:    bus_wr(1'b0, 8'h20, 1'b1);
                4:    bus_rd(1'($urandom_range(0, 1)), r);
                5:    inta_seq(v, e);
                6:    bus_wr(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
                default: begin
                    if ($urandom_range(0, 15) == 0) do_reset();
                    else ticks($urandom_range(1, 3));
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Fixed-priority 8-input interrupt controller that consumes the bus-controller command strobes (`inta_n`, `iorc_n`, `aiowc_n`) and returns interrupt vectors and register data on the CPU-side data bus. It sits directly downstream of the 8288 bus controller in the PC system board and replaces the 8259 for the 8088 interrupt path. It handles edge capture of IRQ lines, masking, the two-pulse INTA acknowledge sequence and non-specific EOI.

## Interface

- `VEC_BASE`, default 8'h08: vector base; bits [2:0] ignored, vector = {VEC_BASE[7:3], level[2:0]}.
- `clk` in 1: system clock, same clock as the 8288.
- `rst_n` in 1: asynchronous, active-low reset.
- `irq` in 8: interrupt requests, asynchronous; IRQ0 has the highest priority.
- `cs_n` in 1: chip select from the I/O address decoder.
- `a0` in 1: register select.
- `iorc_n` in 1: I/O read command from the 8288.
- `aiowc_n` in 1: advanced I/O write command from the 8288.
- `inta_n` in 1: interrupt acknowledge command from the 8288.
- `din` in 8: write data.
- `dout` out 8: read or vector data.
- `dout_en` out 1: drive enable for `dout`.
- `intr` out 1: interrupt request to the CPU.

## Operation

- **Registers**
  - IRR: request register.
  - ISR: in-service register.
  - IMR: mask register, 1 = masked.
- **IRQ capture**
  - Each `irq` bit passes through a 2-flop synchronizer.
  - A synchronized 0→1 transition sets the IRR bit.
- **`intr`**
  - `intr` = 1 when the highest-priority set bit of (IRR & ~IMR) has higher priority than the highest set ISR bit, or ISR is 0.
  - `intr` is registered.
- **Writes**
  - Trigger: first clk where `aiowc_n`=0, `cs_n`=0 and the previous sample of `aiowc_n` was 1 (falling-edge detect).
  - `a0`=1: IMR ← `din`.
  - `a0`=0 with `din[5]`=1: non-specific EOI, which clears the highest-priority set ISR bit.
  - `a0`=0 with `din[5]`=0: ignored.
- **Reads**
  - While `iorc_n`=0 and `cs_n`=0: `dout_en`=1.
  - `a0`=0 returns ISR; `a0`=1 returns IMR.
  - Read data is combinational from the registers.
- **INTA state machine** (states IDLE, ACK1, WAIT2, ACK2)
  - IDLE→ACK1 on an `inta_n` falling edge. On that edge, latch `level` = highest pending unmasked IRR bit, set that ISR bit and clear that IRR bit.
  - Spurious acknowledge: if nothing is pending, `level`=7 and ISR/IRR are unchanged.
  - ACK1→WAIT2 when `inta_n`=1.
  - WAIT2→ACK2 on the next `inta_n` falling edge. In ACK2, `dout`={VEC_BASE[7:3],`level`} and `dout_en`=1 while `inta_n`=0.
  - ACK2→IDLE when `inta_n`=1.
  - `dout_en` = 0 during ACK1.
- **Precedence and conflicts**
  - INTA has precedence over `iorc_n`. `dout_en` is never asserted for a read while the FSM is outside IDLE.
  - Simultaneous IRR set and INTA clear of the same bit in one cycle: the clear wins. A new edge is needed to re-request.
  - EOI with ISR=0: no effect.
  - IMR write during an INTA sequence: the latched `level` is unaffected.

## Timing

- Reset values: IRR=0, ISR=0, IMR=8'hFF, `intr`=0, `dout_en`=0, `dout`=0, FSM=IDLE, synchronizers=0, edge-detect history=1 for command strobes.
- `irq` rise to `intr`: `intr`=1 after the 4th rising clk (2 sync, 1 IRR, 1 `intr` register).
- IMR write to `intr` update: 2 clks.
- EOI to `intr` update: 2 clks.
- `intr` deasserts 1 clk after the ISR update on the first INTA.
- `rst_n` assertion mid-INTA: immediate return to IDLE with `dout_en`=0. A later second INTA pulse is treated as a first pulse.

## Configuration

- `INTR_CTRL_LEVEL_EN` defined: level-triggered mode.
  - Each IRR bit equals the synchronized `irq` level each clk; edge detect is removed.
  - INTA does not clear IRR.
- `INTR_CTRL_LEVEL_EN` undefined: edge-triggered behaviour as above.

## Structure

- Package `pc_bus_pkg` contains:
  - INTA FSM state enum.
  - Register-select constants `A0_CMD`=0 and `A0_MASK`=1.
  - `EOI_BIT`=5.
  - `IMR_RESET`=8'hFF.
- Sub-module `irq_sync`: per-bit 2-flop synchronizer plus rising-edge pulse, parameterised by width. It is instantiated once for `irq`.
- Priority encoder is a function in the package.

## Test plan

- Reset with IMR written to 8'h00, pulse `irq`[3] 0→1 → `intr`=1 after 4 clks. Two INTA pulses → second pulse `dout`=8'h0B with `dout_en`=1. ISR read (`a0`=0) returns 8'h08.
- `irq`[5] and `irq`[1] rise in the same clk → acknowledge returns 8'h09. After EOI (write 8'h20, `a0`=0), `intr` reasserts and the next acknowledge returns 8'h0D.
- IMR=8'hFF, `irq`[0] rises → `intr` stays 0. Write IMR=8'hFE → `intr`=1 after 2 clks.
- With ISR[2] set, `irq`[6] rises → `intr` stays 0 until EOI. `irq`[0] rising → `intr`=1 (nesting).
- INTA with no pending request → vector 8'h0F and ISR unchanged. Reset asserted between the two INTA pulses → `dout_en` stays 0 on the next pulse.
- With `INTR_CTRL_LEVEL_EN`: `irq`[4] held high and acknowledged, then EOI → `intr` reasserts. Dropping `irq`[4] before acknowledge → `intr` falls within 4 clks.
